serie_paralelo_rx: RTL and testbench
====================================

// Module: serie_paralelo_rx
// PURPOSE
//  Receive-side serial-to-parallel stage for one lane of the PHY link.
//  - Consumes the MSB-first serial bitstream produced by the transmit lane's
//    parallel-to-serial stage: one bit per clk_8f; idle bytes are the COM
//    character 0xBC.
//  - Rebuilds bytes and acquires link sync by counting consecutive COM bytes.
//  - After sync, presents data bytes with a valid flag to the downstream
//    byte un-striping stage.
// PARAMETERS
//  COM_CHAR  8'hBC  idle/comma byte value inserted by transmitter when not valid
//  BC_COUNT  4      consecutive COM bytes required to enter ACTIVE (range 1..7)
// PORTS
//  clk_8f     in   1  bit clock; all logic on rising edge
//  reset      in   1  synchronous, active-high reset
//  data_inS   in   1  serial data, MSB of each byte first
//  data_out   out  8  last recovered data byte (held between byte boundaries)
//  valid_out  out  1  data_out carries a data byte (held for the 8-cycle byte period)
//  byte_stb   out  1  one-cycle pulse: a byte boundary was processed this edge
//  active     out  1  link synchronised (ACTIVE state)
// BEHAVIOUR
//  - Reset (sync, high): shift=0, bit_cnt=0, com_cnt=0, state=SEARCH.
//    Outputs: data_out=8'h00, valid_out=0, byte_stb=0, active=0.
//    Reset has priority over all other activity, mid-byte included; partial byte discarded.
//  - Bit capture: each edge shift <= {shift[6:0], data_inS}; bit_cnt 3-bit, wraps 7->0.
//  - Byte completion: edge where bit_cnt==7.
//    - Completed byte B = {shift[6:0], data_inS}.
//    - All byte-level updates below occur on that same edge; results visible the next cycle.
//    - Latency: 8th bit sampled on edge N -> outputs valid after edge N.
//  - byte_stb=1 only in the cycle after a byte completion; 0 otherwise.
//  - FSM SEARCH (active=0, valid_out=0, data_out unchanged):
//    - B==COM_CHAR -> com_cnt+1.
//    - If com_cnt+1==BC_COUNT -> state ACTIVE, active=1, com_cnt=0.
//    - B!=COM_CHAR -> com_cnt=0; stay in SEARCH.
//    - The byte completing the BC_COUNT-th COM is never presented as data.
//  - FSM ACTIVE (active=1); ACTIVE is left only by reset:
//    - B==COM_CHAR -> valid_out=0; data_out unchanged.
//    - B!=COM_CHAR -> data_out=B, valid_out=1.
//    - valid_out and data_out are held until the next byte completion.
//  - com_cnt is 3 bits and never exceeds BC_COUNT-1 (cleared on transition).
//  - A data byte equal to 0xBC is indistinguishable from idle; the transmitter
//    must not send it as data.
// CONFIGURATION
//  BIT_ALIGN_EN defined:
//    - In SEARCH, every edge compares window W={shift[6:0],data_inS} with COM_CHAR.
//    - On W==COM_CHAR the edge is treated as a byte completion of COM
//      (regardless of bit_cnt) and bit_cnt is forced to 0, so the next bit
//      starts a new byte.
//    - W!=COM_CHAR at a bit_cnt==7 edge clears com_cnt as normal.
//    - In ACTIVE the boundary is locked: bit_cnt free-runs; unaligned matches ignored.
//  BIT_ALIGN_EN undefined:
//    - No hunting; byte boundary fixed by reset (bit_cnt free-runs from 0).
//    - Transmitter and receiver must leave reset on the same clk_8f edge.
// TESTING
//  1. Reset asserted 3 cycles -> data_out=00, valid_out=0, byte_stb=0, active=0
//     every cycle of reset.
//  2. Aligned stream BC,BC,BC,BC,A5,BC,3C ->
//     - active rises 1 cycle after 32nd bit.
//     - valid_out=1/data_out=A5 after 40th bit, 0 after 48th bit.
//     - valid_out=1/data_out=3C after 56th bit.
//  3. BC,BC,BC,7E,BC,BC,BC,BC -> active stays 0 through 32nd bit (com_cnt
//     cleared by 7E); active=1 only after 64th bit.
//  4. Reset pulse mid-byte while ACTIVE (after bit 3 of a data byte) ->
//     outputs zero next cycle, active=0; resync needs 4 new COMs.
//  5. BIT_ALIGN_EN: 3 filler bits 101 then BC x4, 5A ->
//     - active=1 after 35th bit.
//     - data_out=5A, valid_out=1 after 43rd bit.
//     - Without the macro, same stream -> active never rises.
//  6. byte_stb check over 100 aligned bytes: exactly one pulse per 8 cycles,
//     100 pulses total.

Source files
------------

// File: rtl/serie_paralelo_rx.sv
// Receive-side serial-to-parallel stage: rebuilds MSB-first bytes, acquires link
// sync on BC_COUNT consecutive COM bytes, then presents data bytes. Optional macro
// BIT_ALIGN_EN enables COM-based bit-boundary hunting while searching for sync.
module serie_paralelo_rx #(
    parameter logic [7:0] COM_CHAR = 8'hBC,
    parameter int         BC_COUNT = 4
) (
    input  logic       clk_8f,
    input  logic       reset,
    input  logic       data_inS,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       byte_stb,
    output logic       active
);

    typedef enum logic {SEARCH, ACTIVE} state_t;

    localparam logic [2:0] COM_LAST = 3'(BC_COUNT - 1);

    state_t     state_q, state_d;
    logic [6:0] shift_q, shift_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [2:0] com_cnt_q, com_cnt_d;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       stb_q, stb_d;

    logic [7:0] byteW;
    logic       isCom;
    logic       alignHit;
    logic       complete;

    assign byteW = {shift_q, data_inS};
    assign isCom = (byteW == COM_CHAR);

`ifdef BIT_ALIGN_EN
    // While hunting, any COM seen in the sliding window redefines the byte boundary.
    assign alignHit = (state_q == SEARCH) && isCom;
`else
    assign alignHit = 1'b0;
`endif

    assign complete = (bit_cnt_q == 3'd7) || alignHit;

    always_ff @(posedge clk_8f) begin
        if (reset) begin
            state_q   <= SEARCH;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            com_cnt_q <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            stb_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            com_cnt_q <= com_cnt_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            stb_q     <= stb_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        com_cnt_d = com_cnt_q;
        shift_d   = byteW[6:0];
        bit_cnt_d = alignHit ? 3'd0 : bit_cnt_q + 3'd1;
        // ACTIVE is only ever left through reset, so only SEARCH needs byte handling here.
        if (complete && state_q == SEARCH) begin
            if (!isCom) begin
                com_cnt_d = '0;
            end else if (com_cnt_q == COM_LAST) begin
                com_cnt_d = '0;
                state_d   = ACTIVE;
            end else begin
                com_cnt_d = com_cnt_q + 3'd1;
            end
        end
    end

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        stb_d   = complete;
        active  = (state_q == ACTIVE);
        if (complete) begin
            if (state_q == SEARCH || isCom) begin
                valid_d = 1'b0;
            end else begin
                data_d  = byteW;
                valid_d = 1'b1;
            end
        end
    end

    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign byte_stb  = stb_q;

endmodule

// File: tb/tb_serie_paralelo_rx.sv
// Self-checking bench for serie_paralelo_rx: a byte-level reference model checked
// every cycle, plus literal checkpoints for the directed scenarios.
module tb_serie_paralelo_rx;

    localparam logic [7:0] COM = 8'hBC;
    localparam int         BCN = 4;

    logic       clk_8f = 1'b0;
    logic       reset = 1'b1;
    logic       data_inS = 1'b0;
    logic [7:0] data_out;
    logic       valid_out;
    logic       byte_stb;
    logic       active;

    serie_paralelo_rx #(.COM_CHAR(COM), .BC_COUNT(BCN)) dut (
        .clk_8f   (clk_8f),
        .reset    (reset),
        .data_inS (data_inS),
        .data_out (data_out),
        .valid_out(valid_out),
        .byte_stb (byte_stb),
        .active   (active)
    );

    always #5 clk_8f = ~clk_8f;

    int testsRun = 0;
    int testsFailed = 0;

    // Reference model state: bits received since the last byte boundary, recent bits,
    // length of the current run of COM bytes, and whether sync was reached.
    bit         bitsQ[$];
    logic [7:0] recent = '0;
    int         comRun = 0;
    bit         synced = 1'b0;
    logic [7:0] expData = '0;
    bit         expValid = 1'b0;
    bit         expStb = 1'b0;
    bit         checkEn = 1'b0;

    int cycleNo = 0;
    int stbCount = 0;
    int lastStb = -1;
    int gapErrors = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic modelStep(input bit b, input bit r);
        bit         boundary;
        bit         hunt;
        logic [7:0] rxByte;
        if (r) begin
            bitsQ.delete();
            recent   = '0;
            comRun   = 0;
            synced   = 1'b0;
            expData  = '0;
            expValid = 1'b0;
            expStb   = 1'b0;
            return;
        end
        recent = {recent[6:0], b};
        bitsQ.push_back(b);
        boundary = (bitsQ.size() == 8);
`ifdef BIT_ALIGN_EN
        hunt = !synced && (recent == COM);
`else
        hunt = 1'b0;
`endif
        expStb = boundary || hunt;
        if (expStb) begin
            rxByte = recent;
            bitsQ.delete();
            if (!synced) begin
                expValid = 1'b0;
                if (rxByte == COM) begin
                    comRun++;
                    if (comRun == BCN) begin
                        synced = 1'b1;
                        comRun = 0;
                    end
                end else begin
                    comRun = 0;
                end
            end else if (rxByte == COM) begin
                expValid = 1'b0;
            end else begin
                expData  = rxByte;
                expValid = 1'b1;
            end
        end
    endtask

    // Per-cycle comparison against the model, plus strobe spacing bookkeeping.
    always @(negedge clk_8f) begin
        cycleNo++;
        if (checkEn) begin
            checkOutput("data_out", 32'(data_out), 32'(expData));
            checkOutput("valid_out", 32'(valid_out), 32'(expValid));
            checkOutput("byte_stb", 32'(byte_stb), 32'(expStb));
            checkOutput("active", 32'(active), 32'(synced));
        end
        if (byte_stb === 1'b1) begin
            stbCount++;
            if (lastStb >= 0 && cycleNo - lastStb != 8) gapErrors++;
            lastStb = cycleNo;
        end
    end

    task automatic applyStimulus(input logic b, input logic r);
        data_inS = b;
        reset    = r;
        @(posedge clk_8f);
        modelStep(b, r);
        #1;
    endtask

    task automatic sendByte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) applyStimulus(v[i], 1'b0);
    endtask

    initial begin
        logic [7:0] seq3 [8];
        logic [7:0] rb;

        // Reset held three cycles; outputs must be quiet in every one.
        applyStimulus(1'b1, 1'b1);
        checkEn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1);
            checkOutput("rst_data", 32'(data_out), 32'h00);
            checkOutput("rst_valid", 32'(valid_out), 32'h0);
            checkOutput("rst_stb", 32'(byte_stb), 32'h0);
            checkOutput("rst_active", 32'(active), 32'h0);
        end

        // Aligned stream BC x4, A5, BC, 3C.
        for (int i = 0; i < 3; i++) sendByte(COM);
        checkOutput("t2_active_bit24", 32'(active), 32'h0);
        sendByte(COM);
        checkOutput("t2_active_bit32", 32'(active), 32'h1);
        checkOutput("t2_valid_bit32", 32'(valid_out), 32'h0);
        sendByte(8'hA5);
        checkOutput("t2_data_bit40", 32'(data_out), 32'hA5);
        checkOutput("t2_valid_bit40", 32'(valid_out), 32'h1);
        checkOutput("t2_stb_bit40", 32'(byte_stb), 32'h1);
        sendByte(COM);
        checkOutput("t2_valid_bit48", 32'(valid_out), 32'h0);
        checkOutput("t2_data_bit48", 32'(data_out), 32'hA5);
        sendByte(8'h3C);
        checkOutput("t2_data_bit56", 32'(data_out), 32'h3C);
        checkOutput("t2_valid_bit56", 32'(valid_out), 32'h1);

        // A non-COM byte breaks the COM run.
        applyStimulus(1'b0, 1'b1);
        seq3 = '{8'hBC, 8'hBC, 8'hBC, 8'h7E, 8'hBC, 8'hBC, 8'hBC, 8'hBC};
        for (int i = 0; i < 8; i++) begin
            sendByte(seq3[i]);
            if (i == 3) checkOutput("t3_active_bit32", 32'(active), 32'h0);
            if (i == 6) checkOutput("t3_active_bit56", 32'(active), 32'h0);
        end
        checkOutput("t3_active_bit64", 32'(active), 32'h1);

        // Reset pulse three bits into a data byte while synchronised.
        sendByte(8'h96);
        checkOutput("t4_data_pre", 32'(data_out), 32'h96);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1);
        checkOutput("t4_rst_data", 32'(data_out), 32'h00);
        checkOutput("t4_rst_valid", 32'(valid_out), 32'h0);
        checkOutput("t4_rst_active", 32'(active), 32'h0);
        for (int i = 0; i < 3; i++) sendByte(COM);
        checkOutput("t4_active_3com", 32'(active), 32'h0);
        sendByte(COM);
        checkOutput("t4_active_4com", 32'(active), 32'h1);
        sendByte(8'h5A);
        checkOutput("t4_data_5a", 32'(data_out), 32'h5A);

        // Three filler bits ahead of the COM run: only bit alignment can lock on.
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) sendByte(COM);
`ifdef BIT_ALIGN_EN
        checkOutput("t5_active_bit35", 32'(active), 32'h1);
`else
        checkOutput("t5_active_bit35", 32'(active), 32'h0);
`endif
        sendByte(8'h5A);
`ifdef BIT_ALIGN_EN
        checkOutput("t5_data_bit43", 32'(data_out), 32'h5A);
        checkOutput("t5_valid_bit43", 32'(valid_out), 32'h1);
`else
        checkOutput("t5_valid_bit43", 32'(valid_out), 32'h0);
`endif
        sendByte(8'h00);
        sendByte(8'h00);
`ifndef BIT_ALIGN_EN
        checkOutput("t5_active_end", 32'(active), 32'h0);
`endif

        // Strobe cadence over 100 aligned bytes.
        applyStimulus(1'b0, 1'b1);
        for (int i = 0; i < 4; i++) sendByte(COM);
        @(negedge clk_8f);
        #1;
        stbCount  = 0;
        lastStb   = -1;
        gapErrors = 0;
        for (int i = 0; i < 100; i++) begin
            rb = 8'($urandom_range(0, 255));
            sendByte(rb);
        end
        @(negedge clk_8f);
        #1;
        checkOutput("t6_stb_count", 32'(stbCount), 32'd100);
        checkOutput("t6_stb_gap_errors", 32'(gapErrors), 32'd0);

        // Random byte mix, heavy on COM, with occasional resets at arbitrary bits.
        for (int i = 0; i < 400; i++) begin
            rb = ($urandom_range(0, 1) == 0) ? COM : 8'($urandom_range(0, 255));
            for (int j = 7; j >= 0; j--)
                applyStimulus(rb[j], ($urandom_range(0, 299) == 0));
        end

        // Fully random bits.
        for (int i = 0; i < 1500; i++)
            applyStimulus(1'($urandom_range(0, 1)), ($urandom_range(0, 499) == 0));

        @(negedge clk_8f);
        #1;
        checkEn = 1'b0;
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
